// File: rtl/angle_ram_loader.sv
// Sequential writer for the single-port angle-table RAM: loads len words from a valid/ready stream into addresses 0..len-1.
// Optional read-back checksum verify pass is built in when ANGLE_RAM_LOADER_VERIFY_EN is defined.
module angle_ram_loader #(
  parameter int c_ADDR_WIDTH = 10,
  parameter int c_DATA_WIDTH = 32,
  parameter int c_RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [c_ADDR_WIDTH:0]   len_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [c_DATA_WIDTH-1:0] s_data_i,
  output logic [c_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [c_DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                    ram_wr_en_o,
  output logic                    ram_clk_en_o,
  input  logic [c_DATA_WIDTH-1:0] ram_rd_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [c_ADDR_WIDTH:0]   wr_count_o,
  output logic                    chk_err_o,
  output logic [1:0]              dbg_state_o
);

  localparam int AW = c_ADDR_WIDTH;
  localparam int DW = c_DATA_WIDTH;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q;
  logic        s_ready_q;
  logic        done_q;
  logic [AW:0] len_q;
  logic [AW:0] wr_count_q;

  logic        wr_hs;
  logic        last_wr;
  logic        start_ok;
  logic [AW:0] wr_count_inc;
  logic [AW:0] len_sat;

  // Stream handshake: a word transfers on every rising edge where s_valid_i && s_ready_o.
  // s_ready_o is registered and is high for every cycle of LOAD; the source holds s_data_i until it transfers.
  assign wr_hs        = s_valid_i & s_ready_q;
  assign wr_count_inc = wr_count_q + ONE;
  assign last_wr      = wr_hs && (wr_count_inc == len_q);
  assign start_ok     = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign len_sat      = len_i[AW] ? LEN_MAX : len_i;

`ifdef ANGLE_RAM_LOADER_VERIFY_EN
  logic [DW-1:0]           csum_wr_q;
  logic [DW-1:0]           csum_rd_q;
  logic [DW-1:0]           csum_rd_nxt;
  logic [AW:0]             rd_cnt_q;
  logic [AW:0]             smp_cnt_q;
  logic [c_RD_LATENCY-1:0] rd_pipe_q;
  logic                    chk_err_q;
  logic                    rd_issue;
  logic                    rd_sample;

  assign rd_issue     = (state_q == S_VERIFY) && (rd_cnt_q != len_q);
  // rd_pipe_q tracks which cycles carry read data back from the RAM.
  assign rd_sample    = rd_pipe_q[c_RD_LATENCY-1];
  assign csum_rd_nxt  = csum_rd_q + ram_rd_data_i;
  assign ram_addr_o   = (state_q == S_VERIFY) ? rd_cnt_q[AW-1:0] : wr_count_q[AW-1:0];
  assign ram_clk_en_o = wr_hs | rd_issue;
  assign chk_err_o    = chk_err_q;
`else
  logic unused_rd;

  assign unused_rd    = (^ram_rd_data_i) ^ (c_RD_LATENCY == 0);
  assign ram_addr_o   = wr_count_q[AW-1:0];
  assign ram_clk_en_o = wr_hs;
  assign chk_err_o    = 1'b0;
`endif

  assign ram_wr_en_o   = wr_hs;
  assign ram_wr_data_o = s_data_i;
  assign s_ready_o     = s_ready_q;
  assign done_o        = done_q;
  assign wr_count_o    = wr_count_q;
  assign busy_o        = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      s_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      wr_count_q <= '0;
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
      csum_wr_q  <= '0;
      csum_rd_q  <= '0;
      rd_cnt_q   <= '0;
      smp_cnt_q  <= '0;
      rd_pipe_q  <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
      rd_pipe_q[0] <= rd_issue;
      for (int i = 1; i < c_RD_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) done_q <= 1'b1;
          if (start_ok) begin
            len_q      <= len_sat;
            wr_count_q <= '0;
            done_q     <= 1'b0;
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
            csum_wr_q  <= '0;
            csum_rd_q  <= '0;
            rd_cnt_q   <= '0;
            smp_cnt_q  <= '0;
            rd_pipe_q  <= '0;
            chk_err_q  <= 1'b0;
`endif
            // A zero-length load completes without touching the RAM.
            if (len_sat == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q   <= S_LOAD;
              s_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wr_hs) begin
            wr_count_q <= wr_count_inc;
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
            csum_wr_q  <= csum_wr_q + s_data_i;
`endif
            if (last_wr) begin
              s_ready_q <= 1'b0;
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
              state_q   <= S_VERIFY;
`else
              state_q   <= S_DONE;
`endif
            end
          end
        end
`ifdef ANGLE_RAM_LOADER_VERIFY_EN
        S_VERIFY: begin
          if (rd_issue) rd_cnt_q <= rd_cnt_q + ONE;
          if (rd_sample) begin
            csum_rd_q <= csum_rd_nxt;
            smp_cnt_q <= smp_cnt_q + ONE;
            if ((smp_cnt_q + ONE) == len_q) begin
              chk_err_q <= (csum_rd_nxt != csum_wr_q);
              state_q   <= S_DONE;
            end
          end
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_ram_loader.sv
// Directed bench for angle_ram_loader (AW=4, DW=32, read latency 2) with a behavioural SPRAM model.
module tb_angle_ram_loader;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wr_data_o;
  logic          ram_wr_en_o;
  logic          ram_clk_en_o;
  logic [DW-1:0] ram_rd_data_i;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   wr_count_o;
  logic          chk_err_o;
  logic [1:0]    dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  angle_ram_loader #(
    .c_ADDR_WIDTH(AW),
    .c_DATA_WIDTH(DW),
    .c_RD_LATENCY(RL)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .len_i(len_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_data_i(s_data_i),
    .ram_addr_o(ram_addr_o),
    .ram_wr_data_o(ram_wr_data_o),
    .ram_wr_en_o(ram_wr_en_o),
    .ram_clk_en_o(ram_clk_en_o),
    .ram_rd_data_i(ram_rd_data_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .wr_count_o(wr_count_o),
    .chk_err_o(chk_err_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  // SPRAM model plus write logger
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd1_q, rd2_q;
  logic          corrupt_en = 1'b0;
  int            cyc_q = 0;
  int            clk_en_cnt_q = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  logic [DW-1:0] exp_q[$];

  assign ram_rd_data_i = rd2_q;

  always @(posedge clk_i) begin
    cyc_q <= cyc_q + 1;
    if (ram_clk_en_o) clk_en_cnt_q <= clk_en_cnt_q + 1;
    if (ram_wr_en_o) begin
      mem[ram_addr_o] <= ram_wr_data_o;
      wa_q.push_back(ram_addr_o);
      wd_q.push_back(ram_wr_data_o);
      wc_q.push_back(cyc_q);
    end
    if (ram_clk_en_o && !ram_wr_en_o)
      rd1_q <= (corrupt_en && ram_addr_o == 4'd2) ? (mem[ram_addr_o] ^ 32'h0000_00FF) : mem[ram_addr_o];
    rd2_q <= rd1_q;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [AW:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
  endtask

  // One stream cycle; exp_wr is whether a RAM write is expected this cycle.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic exp_wr);
    s_valid_i = v;
    s_data_i  = d;
    @(negedge clk_i);
    check("wr_en", ram_wr_en_o, exp_wr);
`ifndef ANGLE_RAM_LOADER_VERIFY_EN
    check("clk_en", ram_clk_en_o, exp_wr);
`endif
    if (exp_wr) exp_q.push_back(d);
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int waited);
    waited = 0;
    while (!done_o && waited < 64) begin
      tick();
      waited++;
    end
    check(tag, done_o, 1'b1);
    check("busy_at_done", busy_o, 1'b0);
    check("s_ready_at_done", s_ready_o, 1'b0);
  endtask

  task automatic check_log(input int n);
    int m;
    check("write_count", wa_q.size(), n);
    m = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check("write_addr", wa_q[i], i);
      check("write_data", wd_q[i], exp_q[i]);
    end
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ce0;
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    check("rst_s_ready", s_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_wr_count", wr_count_o, 0);
    check("rst_wr_en", ram_wr_en_o, 1'b0);
    check("rst_clk_en", ram_clk_en_o, 1'b0);
    check("rst_chk_err", chk_err_o, 1'b0);
    check("rst_state", dbg_state_o, 2'd0);

    // len=4 back-to-back
    start_load(5'd4);
    check("t2_s_ready", s_ready_o, 1'b1);
    check("t2_busy", busy_o, 1'b1);
    drive(1'b1, 32'h11, 1'b1);
    drive(1'b1, 32'h22, 1'b1);
    drive(1'b1, 32'h33, 1'b1);
    drive(1'b1, 32'h44, 1'b1);
    check("t2_s_ready_low", s_ready_o, 1'b0);
    check("t2_wr_count", wr_count_o, 4);
    check("t2_done_not_yet", done_o, 1'b0);
    for (int i = 1; i < 4; i++) check("t2_consecutive", wc_q[i] - wc_q[0], i);
    wait_done("t2_done", w);
`ifndef ANGLE_RAM_LOADER_VERIFY_EN
    check("t2_done_latency", w, 1);
`endif
    check("t2_wr_count_final", wr_count_o, 4);
    check_log(4);

    // len=4 with valid gaps 1,0,0,1,1,0,1
    start_load(5'd4);
    check("t3_done_cleared", done_o, 1'b0);
    drive(1'b1, 32'hA0, 1'b1);
    drive(1'b0, 32'hBAD0, 1'b0);
    drive(1'b0, 32'hBAD1, 1'b0);
    drive(1'b1, 32'hA1, 1'b1);
    drive(1'b1, 32'hA2, 1'b1);
    drive(1'b0, 32'hBAD2, 1'b0);
    drive(1'b1, 32'hA3, 1'b1);
    wait_done("t3_done", w);
    check("t3_wr_count", wr_count_o, 4);
    check_log(4);

    // len=0: no RAM access, done one cycle later
    ce0 = clk_en_cnt_q;
    start_load(5'd0);
    check("t4_len0_busy", busy_o, 1'b0);
    check("t4_len0_done_cleared", done_o, 1'b0);
    wait_done("t4_len0_done", w);
    check("t4_len0_latency", w, 1);
    check("t4_len0_wr_count", wr_count_o, 0);
    check("t4_len0_no_clk_en", clk_en_cnt_q - ce0, 0);

    // start while busy is ignored
    start_load(5'd8);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC0 + i, 1'b1);
    start_i = 1'b1; len_i = 5'd2;
    drive(1'b1, 32'hC3, 1'b1);
    start_i = 1'b0;
    check("t4_still_busy", busy_o, 1'b1);
    check("t4_wr_count_mid", wr_count_o, 4);
    for (int i = 4; i < 8; i++) drive(1'b1, 32'hC0 + i, 1'b1);
    wait_done("t4_done", w);
    check("t4_wr_count", wr_count_o, 8);
    check_log(8);

    // Reset mid-load after 3 of 8 words
    start_load(5'd8);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hE0 + i, 1'b1);
    rst_i = 1'b1;
    #1;
    check("t1_rst_s_ready", s_ready_o, 1'b0);
    check("t1_rst_busy", busy_o, 1'b0);
    check("t1_rst_done", done_o, 1'b0);
    check("t1_rst_wr_count", wr_count_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); exp_q.delete();
    start_load(5'd8);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + i, 1'b1);
    wait_done("t1_done", w);
    check("t1_wr_count", wr_count_o, 8);
    check_log(8);

    // len=21 saturates to 16
    start_load(5'd21);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h200 + i, 1'b1);
    check("t5_s_ready_low", s_ready_o, 1'b0);
    check("t5_last_addr", wa_q[wa_q.size()-1], 4'hF);
    drive(1'b1, 32'hDEAD, 1'b0);
    wait_done("t5_done", w);
    check("t5_wr_count", wr_count_o, 16);
    check_log(16);

`ifdef ANGLE_RAM_LOADER_VERIFY_EN
    // Verify: clean load, then corrupted read of address 2
    start_load(5'd4);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h1000 * (i + 1), 1'b1);
    wait_done("t6_clean_done", w);
    check("t6_clean_chk_err", chk_err_o, 1'b0);
    check_log(4);
    corrupt_en = 1'b1;
    start_load(5'd4);
    check("t6_chk_err_cleared", chk_err_o, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h1000 * (i + 1), 1'b1);
    wait_done("t6_corrupt_done", w);
    check("t6_corrupt_chk_err", chk_err_o, 1'b1);
    corrupt_en = 1'b0;
    check_log(4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
